// File: rtl/spi_reg_bank_if.sv
// Byte-level handshake between spi_slave (master side) and the register bank (slave side).
interface spi_reg_bank_if;
    logic       ss;
    logic [7:0] rx_data;
    logic       rx_dv;
    logic [7:0] tx_data;
    logic       tx_we;
    logic       tx_halt;

    modport master (output ss, rx_data, rx_dv, tx_halt, input tx_data, tx_we);
    modport slave  (input ss, rx_data, rx_dv, tx_halt, output tx_data, tx_we);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI-addressed register bank: command byte + MSB-first multi-byte register data,
// auto-incrementing address, hardware write port and atomic (snapshotted) reads.
module spi_reg_bank #(
    parameter int NUM_REGS  = 8,
    parameter int REG_WIDTH = 64,
    parameter int ADDR_W    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    spi_reg_bank_if.slave                 spi,
    input  logic                          hw_we,
    input  logic [ADDR_W-1:0]             hw_addr,
    input  logic [REG_WIDTH-1:0]          hw_d,
    output logic [NUM_REGS*REG_WIDTH-1:0] regs_q,
    output logic                          spi_wr_stb,
    output logic [ADDR_W-1:0]             spi_wr_addr,
    output logic                          tx_underrun
);
    localparam int BYTES = REG_WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WRITE, S_RD_LOAD, S_RD_WAIT, S_INVALID
    } state_e;

    state_e                             state_q;
    logic [ADDR_W-1:0]                  addr_q, wr_addr_q;
    logic [CNT_W-1:0]                   cnt_q;
    logic [REG_WIDTH-1:0]               wsh_q, shadow_q;
    logic [7:0]                         tx_data_q;
    logic                               tx_pend_q, wr_stb_q, underrun_q, inv_rd_q;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0] bank_q, bank_d;

    logic                 last_byte, tx_fire, spi_commit;
    logic [ADDR_W-1:0]    addr_inc;
    logic [REG_WIDTH-1:0] wsh_nxt, rd_src;
    logic [CNT_W-1:0]     byte_idx;
    logic [7:0]           rd_byte;

    assign last_byte  = (cnt_q == CNT_W'(BYTES - 1));
    assign addr_inc   = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + 1'b1;
    assign tx_fire    = tx_pend_q & ~spi.tx_halt;
    assign spi_commit = (state_q == S_WRITE) && !spi.ss && spi.rx_dv && last_byte;
    assign wsh_nxt    = (wsh_q << 8) | REG_WIDTH'(spi.rx_data);

    // Byte 0 reads the live register (it is snapshotted in the same edge);
    // the rest come from the shadow so hw updates cannot tear a register.
    assign rd_src   = (cnt_q == '0) ? bank_q[addr_q] : shadow_q;
    assign byte_idx = CNT_W'(BYTES - 1) - cnt_q;
    assign rd_byte  = rd_src[{byte_idx, 3'b000} +: 8];

    assign spi.tx_data  = tx_data_q;
    assign spi.tx_we    = tx_fire;
    assign regs_q       = bank_q;
    assign spi_wr_stb   = wr_stb_q;
    assign spi_wr_addr  = wr_addr_q;
    assign tx_underrun  = underrun_q;

    // SPI commit has priority over a same-cycle hw write to the same register.
    always_comb begin
        bank_d = bank_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (spi_commit && addr_q == ADDR_W'(i))
                bank_d[i] = wsh_nxt;
            else if (hw_we && hw_addr == ADDR_W'(i))
                bank_d[i] = hw_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bank_q <= '0;
        else      bank_q <= bank_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            cnt_q      <= '0;
            wsh_q      <= '0;
            shadow_q   <= '0;
            tx_data_q  <= 8'h00;
            tx_pend_q  <= 1'b0;
            wr_stb_q   <= 1'b0;
            underrun_q <= 1'b0;
            inv_rd_q   <= 1'b0;
        end else begin
            wr_stb_q   <= 1'b0;
            underrun_q <= 1'b0;
            if (tx_fire) tx_pend_q <= 1'b0;

            if (spi.ss && state_q != S_IDLE) begin
                state_q   <= S_IDLE;
                tx_pend_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                case (state_q)
                    S_IDLE: if (!spi.ss) begin
                        state_q <= S_CMD;
                        cnt_q   <= '0;
                    end
                    S_CMD: if (spi.rx_dv) begin
                        addr_q   <= ADDR_W'(spi.rx_data[6:0]);
                        inv_rd_q <= spi.rx_data[7];
                        cnt_q    <= '0;
                        if (int'(spi.rx_data[6:0]) >= NUM_REGS) begin
                            state_q <= S_INVALID;
                            if (spi.rx_data[7]) begin
                                tx_data_q <= 8'hFF;
                                tx_pend_q <= 1'b1;
                            end
                        end else begin
                            state_q <= spi.rx_data[7] ? S_RD_LOAD : S_WRITE;
                        end
                    end
                    S_WRITE: if (spi.rx_dv) begin
                        wsh_q <= wsh_nxt;
                        if (last_byte) begin
                            cnt_q     <= '0;
                            addr_q    <= addr_inc;
                            wr_stb_q  <= 1'b1;
                            wr_addr_q <= addr_q;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    // Wait until the previous byte has gone out before overwriting tx_data.
                    S_RD_LOAD: if (!tx_pend_q || !spi.tx_halt) begin
                        if (cnt_q == '0) shadow_q <= bank_q[addr_q];
                        tx_data_q <= rd_byte;
                        tx_pend_q <= 1'b1;
                        state_q   <= S_RD_WAIT;
                    end
                    S_RD_WAIT: if (spi.rx_dv) begin
                        if (tx_pend_q && spi.tx_halt) underrun_q <= 1'b1;
                        if (last_byte) begin
                            cnt_q  <= '0;
                            addr_q <= addr_inc;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        state_q <= S_RD_LOAD;
                    end
                    S_INVALID: if (spi.rx_dv && inv_rd_q) begin
                        if (tx_pend_q && spi.tx_halt) underrun_q <= 1'b1;
                        tx_data_q <= 8'hFF;
                        tx_pend_q <= 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
Parametrised successor to the single-register SPI controller: a bank of NUM_REGS registers, each REG_WIDTH bits wide, sitting between the spi_slave byte interface and user logic. Each SPI frame starts with a command byte (R/W + start address), followed by multi-byte register data. The address auto-increments across registers. A hardware write port lets user logic (e.g. RTC counters) update registers. Reads snapshot whole registers, so values are always atomic.

Parameters:
NUM_REGS, 8, number of registers in bank (1..128)
REG_WIDTH, 64, bits per register (8..64, multiple of 8); BYTES = REG_WIDTH/8
ADDR_W, 3, address width, >= clog2(NUM_REGS)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
ss  in  1  SPI slave select, active-low, already synchronised to clk
rx_data  in  8  byte received from spi_slave
rx_dv  in  1  one-cycle pulse: rx_data valid
tx_data  out  8  byte to spi_slave tx buffer
tx_we  out  1  one-cycle pulse: load tx_data into spi_slave
tx_halt  in  1  high: spi_slave cannot accept tx_we this cycle
hw_we  in  1  hardware write enable
hw_addr  in  ADDR_W  hardware write address
hw_d  in  REG_WIDTH  hardware write data
regs_q  out  NUM_REGS*REG_WIDTH  flat register contents, reg i at [i*REG_WIDTH +: REG_WIDTH]
spi_wr_stb  out  1  one-cycle pulse when SPI commits a register
spi_wr_addr  out  ADDR_W  address committed with spi_wr_stb
tx_underrun  out  1  one-cycle pulse: read byte requested before previous tx byte loaded

Behaviour:
- Reset (rst=0, async): all registers 0, tx_data=0x00, tx_we=0, spi_wr_stb=0, spi_wr_addr=0, tx_underrun=0, FSM=IDLE, byte counter 0.
- States: IDLE, CMD, WRITE, RD_LOAD, RD_WAIT, INVALID.
- IDLE: ss=1. On ss=0 -> CMD.
- ss=1 in any non-IDLE state -> IDLE next cycle. A partially assembled write register is discarded, with no commit. Pending tx is dropped.
- CMD: first rx_dv byte: bit7=1 read, 0 write; bits[6:0]=start addr.
  - If start addr >= NUM_REGS -> INVALID.
  - Else, for a write -> WRITE. For a read -> RD_LOAD.
- WRITE: each rx_dv shifts the byte in, MSB-first (first byte = bits[REG_WIDTH-1:REG_WIDTH-8]).
  - On the BYTES-th byte, the register commits in the cycle after rx_dv.
  - spi_wr_stb pulses in that same cycle with spi_wr_addr.
  - Then addr = (addr==NUM_REGS-1) ? 0 : addr+1, and the byte count resets.
- RD_LOAD: at byte 0 of each register, snapshot reg[addr] into a shadow. All bytes of that register come from the shadow. Load the next byte MSB-first into tx_data, then -> RD_WAIT.
  - tx_we is asserted on the first cycle tx_halt=0. It is held pending while tx_halt=1.
  - First tx_we for the command's start register is no earlier than 1 cycle after the command rx_dv.
- RD_WAIT: the next rx_dv (dummy byte) -> RD_LOAD for the following byte.
  - After the BYTES-th byte, addr increments with the same wrap rule.
  - If rx_dv arrives while tx_we is still pending, tx_underrun pulses 1 cycle. The pending byte is still sent and sequencing continues.
- INVALID: all write bytes are ignored. Reads load tx_data=0xFF per rx_dv (plus one after the command). No commit, no spi_wr_stb.
- Hardware write: hw_we=1 updates reg[hw_addr] the next cycle. hw_addr >= NUM_REGS is ignored.
- Same-cycle SPI commit and hw_we to the same address: the SPI value wins, the hw write is dropped. Different addresses: both take effect.
- A read in progress is unaffected by hw writes to the snapshotted register until the next register boundary.
- rx_dv in IDLE is ignored.

Test Plan:
1. Write frame: ss=0, bytes 0x02, 01..08 (REG_WIDTH=64) -> reg2=0x0102030405060708; one spi_wr_stb with spi_wr_addr=2; other regs remain 0.
2. Burst wrap: NUM_REGS=8, write starting at addr 7 with 16 data bytes -> reg7 and reg0 written; two strobes, at addr 7 then addr 0.
3. Atomic read: reg1=0x1122334455667788. Send read 0x81 plus 8 dummies, with hw_we writing reg1=0 mid-frame after byte 3 -> tx bytes 11,22,...,88; reg1=0 afterwards.
4. Abort: write cmd 0x03 + 5 bytes, then ss=1 -> reg3 unchanged, no spi_wr_stb, FSM=IDLE; the next frame parses its first byte as a command.
5. Invalid/collision: cmd 0x85 with NUM_REGS=4 -> tx bytes all 0xFF. SPI commit and hw_we to reg0 in the same cycle -> reg0 holds the SPI value.
6. Backpressure: tx_halt=1 for 4 cycles after the read command -> tx_we asserted on the first low cycle. A dummy rx_dv while pending -> tx_underrun pulses once.
